fifo_shift_round: RTL and testbench



---
 rtl/fifo_shift_round_pkg.sv | 35 +++
 rtl/fifo_shift_round_counter.sv | 26 ++
 rtl/fifo_shift_round_register.sv | 37 +++
 rtl/fifo_shift_round.sv | 137 +++++++++++++
 tb/tb_fifo_shift_round.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_shift_round_pkg.sv
// Shared constants and helpers for the narrow/wide stream width converter.
// Holds the ORAM data-path widths, the log2 helper and the conversion-mode selection.
package fifo_shift_round_pkg;

    localparam int ORAMB    = 512;
    localparam int FEDWidth = 64;
    localparam int ORAMU    = 32;

    typedef enum logic [1:0] {
        ModeEqual  = 2'd0,
        ModePack   = 2'd1,
        ModeUnpack = 2'd2
    } convMode_t;

    // Ceiling log2: the number of bits needed to count 0..value-1.
    function automatic int log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    function automatic int ratioOf(input int iWidth, input int oWidth);
        return (iWidth > oWidth) ? iWidth / oWidth : oWidth / iWidth;
    endfunction

    function automatic convMode_t convModeOf(input int iWidth, input int oWidth);
        if (iWidth < oWidth) return ModePack;
        if (iWidth > oWidth) return ModeUnpack;
        return ModeEqual;
    endfunction

endpackage

// File: rtl/fifo_shift_round_counter.sv
// Shared beat counter: synchronous Reset/Set/Load, each taking priority over Enable.
// Set drives all ones; Load takes In; Enable adds one and wraps at the counter width.
module Counter
    import fifo_shift_round_pkg::*;
#(
    parameter int Width = log2(ORAMB / FEDWidth)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Set,
    input  logic             Load,
    input  logic             Enable,
    input  logic [Width-1:0] In,
    output logic [Width-1:0] Count
);

    // NOTE: sequential state always uses non-blocking assignments so every
    // reader of Count sees the pre-edge value within the same clock edge.
    always_ff @(posedge Clock) begin
        if (Reset)       Count <= '0;
        else if (Set)    Count <= '1;
        else if (Load)   Count <= In;
        else if (Enable) Count <= Count + 1'b1;
    end

endmodule

// File: rtl/fifo_shift_round_register.sv
// One-entry valid/ready register stage: accepts whenever empty or draining this cycle.
// Full is set by an accept and cleared by an output transfer that has no new input behind it.
module fifo_register
    import fifo_shift_round_pkg::*;
#(
    parameter int Width = FEDWidth
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [Width-1:0] InData,
    input  logic             InValid,
    output logic             InAccept,
    output logic [Width-1:0] OutData,
    output logic             OutSend,
    input  logic             OutReady
);

    logic full;

    assign InAccept = ~full | OutReady;
    assign OutSend  = full;

    // NOTE: the data register is reset as well, so OutData is a known value
    // straight after Reset instead of whatever the flops powered up with.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            full    <= 1'b0;
            OutData <= '0;
        end else if (InValid & InAccept) begin
            full    <= 1'b1;
            OutData <= InData;
        end else if (OutReady) begin
            full    <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_shift_round.sv
// Valid/ready width converter between a narrow and a wide stream, LSB chunk first,
// with an optional fifo_register stage on the output side.
module fifo_shift_round
    import fifo_shift_round_pkg::*;
#(
    parameter int IWidth   = FEDWidth,
    parameter int OWidth   = FEDWidth,
    parameter int Register = 0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [IWidth-1:0] InData,
    input  logic              InValid,
    output logic              InAccept,
    output logic [OWidth-1:0] OutData,
    output logic              OutValid,
    input  logic              OutReady
);

    localparam convMode_t Mode = convModeOf(IWidth, OWidth);

    logic [OWidth-1:0] convData;
    logic              convValid;
    logic              convReady;

    if (Mode == ModePack) begin : genPack
        localparam int Ratio = ratioOf(IWidth, OWidth);
        localparam int CountWidth = (Ratio > 1) ? log2(Ratio) : 1;
        localparam logic [CountWidth-1:0] LastBeat = CountWidth'(Ratio - 1);

        logic [OWidth-1:0]     packReg;
        logic                  full;
        logic [CountWidth-1:0] count;
        logic                  beat;
        logic                  lastBeat;

        // A pop and a new beat may share a cycle; that beat starts the next word at chunk 0.
        assign InAccept = ~full | convReady;
        assign beat     = InValid & InAccept;
        assign lastBeat = beat & (count == LastBeat);

        Counter #(.Width(CountWidth)) beatCounter (
            .Clock  (Clock),
            .Reset  (Reset | lastBeat),
            .Set    (1'b0),
            .Load   (1'b0),
            .Enable (beat),
            .In     ('0),
            .Count  (count)
        );

        always_ff @(posedge Clock) begin
            if (Reset) begin
                packReg <= '0;
                full    <= 1'b0;
            end else begin
                if (beat) packReg[int'(count)*IWidth +: IWidth] <= InData;
                if (lastBeat)       full <= 1'b1;
                else if (convReady) full <= 1'b0;
            end
        end

        assign convData  = packReg;
        assign convValid = full;
    end else if (Mode == ModeUnpack) begin : genUnpack
        localparam int Ratio = ratioOf(IWidth, OWidth);
        localparam int CountWidth = (Ratio > 1) ? log2(Ratio) : 1;
        localparam logic [CountWidth-1:0] LastBeat = CountWidth'(Ratio - 1);

        logic [IWidth-1:0]     holdReg;
        logic                  full;
        logic [CountWidth-1:0] count;
        logic                  pop;
        logic                  lastPop;
        logic                  load;

        assign pop      = full & convReady;
        assign lastPop  = pop & (count == LastBeat);
        // Accepting during the last chunk's transfer keeps words back-to-back.
        assign InAccept = ~full | (convReady & (count == LastBeat));
        assign load     = InValid & InAccept;

        Counter #(.Width(CountWidth)) beatCounter (
            .Clock  (Clock),
            .Reset  (Reset | lastPop),
            .Set    (1'b0),
            .Load   (1'b0),
            .Enable (pop),
            .In     ('0),
            .Count  (count)
        );

        always_ff @(posedge Clock) begin
            if (Reset) begin
                holdReg <= '0;
                full    <= 1'b0;
            end else if (load) begin
                holdReg <= InData;
                full    <= 1'b1;
            end else if (lastPop) begin
                full    <= 1'b0;
            end
        end

        assign convData  = holdReg[int'(count)*OWidth +: OWidth];
        assign convValid = full;
    end else begin : genEqual
        fifo_register #(.Width(OWidth)) equalStage (
            .Clock    (Clock),
            .Reset    (Reset),
            .InData   (InData),
            .InValid  (InValid),
            .InAccept (InAccept),
            .OutData  (convData),
            .OutSend  (convValid),
            .OutReady (convReady)
        );
    end

    if (Register != 0) begin : genOutStage
        fifo_register #(.Width(OWidth)) outStage (
            .Clock    (Clock),
            .Reset    (Reset),
            .InData   (convData),
            .InValid  (convValid),
            .InAccept (convReady),
            .OutData  (OutData),
            .OutSend  (OutValid),
            .OutReady (OutReady)
        );
    end else begin : genDirect
        assign OutData   = convData;
        assign OutValid  = convValid;
        assign convReady = OutReady;
    end

endmodule

// File: tb/tb_fifo_shift_round.sv
// Scoreboard bench for fifo_shift_round: 512->64 unpack, 64->512 pack with output register,
// and 64->64 pass-through, each checked against a word/chunk-level reference model.
module tb_fifo_shift_round;

    logic Clock;
    logic Reset;

    logic [511:0] uInData;
    logic         uInValid, uInAccept;
    logic [63:0]  uOutData;
    logic         uOutValid, uOutReady;

    logic [63:0]  pInData;
    logic         pInValid, pInAccept;
    logic [511:0] pOutData;
    logic         pOutValid, pOutReady;

    logic [63:0]  eInData;
    logic         eInValid, eInAccept;
    logic [63:0]  eOutData;
    logic         eOutValid, eOutReady;

    fifo_shift_round #(.IWidth(512), .OWidth(64), .Register(0)) dutUnpack (
        .Clock(Clock), .Reset(Reset),
        .InData(uInData), .InValid(uInValid), .InAccept(uInAccept),
        .OutData(uOutData), .OutValid(uOutValid), .OutReady(uOutReady)
    );

    fifo_shift_round #(.IWidth(64), .OWidth(512), .Register(1)) dutPack (
        .Clock(Clock), .Reset(Reset),
        .InData(pInData), .InValid(pInValid), .InAccept(pInAccept),
        .OutData(pOutData), .OutValid(pOutValid), .OutReady(pOutReady)
    );

    fifo_shift_round #(.IWidth(64), .OWidth(64), .Register(0)) dutEqual (
        .Clock(Clock), .Reset(Reset),
        .InData(eInData), .InValid(eInValid), .InAccept(eInAccept),
        .OutData(eOutData), .OutValid(eOutValid), .OutReady(eOutReady)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: expected output queues plus the partial packed word.
    logic [63:0]  uExp[$];
    logic [511:0] pExp[$];
    logic [63:0]  eExp[$];
    logic [511:0] pPartial = '0;
    int           pBeat = 0;
    int           uIdx = 0;

    bit uRand = 0, pRand = 0, eRand = 0;

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [511:0] actual, input logic [511:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %h required %h", name, actual, expected);
        end
    endtask

    task automatic timeoutFail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out waiting on the DUT", name);
    endtask

    function automatic logic [511:0] randWide();
        logic [511:0] w;
        for (int i = 0; i < 16; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // Output readiness: constant 1, or a fresh coin flip each cycle when the rand flag is set.
    initial begin
        uOutReady = 1'b1; pOutReady = 1'b1; eOutReady = 1'b1;
        forever begin
            @(posedge Clock); #1;
            uOutReady = uRand ? 1'($urandom_range(0, 1)) : 1'b1;
            pOutReady = pRand ? 1'($urandom_range(0, 1)) : 1'b1;
            eOutReady = eRand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // All send tasks start and end at posedge+1 so consecutive calls are back-to-back.
    task automatic sendU(input logic [511:0] d);
        int n = 0;
        uInData = d; uInValid = 1'b1;
        @(negedge Clock);
        while (!uInAccept && n < 200) begin @(negedge Clock); n++; end
        if (uInAccept) for (int k = 0; k < 8; k++) uExp.push_back(d[k*64 +: 64]);
        else timeoutFail("u_send");
        @(posedge Clock); #1;
        uInValid = 1'b0;
    endtask

    task automatic sendP(input logic [63:0] d);
        int n = 0;
        pInData = d; pInValid = 1'b1;
        @(negedge Clock);
        while (!pInAccept && n < 200) begin @(negedge Clock); n++; end
        if (pInAccept) begin
            pPartial[pBeat*64 +: 64] = d;
            pBeat++;
            if (pBeat == 8) begin
                pExp.push_back(pPartial);
                pPartial = '0;
                pBeat = 0;
            end
        end else timeoutFail("p_send");
        @(posedge Clock); #1;
        pInValid = 1'b0;
    endtask

    task automatic sendE(input logic [63:0] d);
        int n = 0;
        eInData = d; eInValid = 1'b1;
        @(negedge Clock);
        while (!eInAccept && n < 200) begin @(negedge Clock); n++; end
        if (eInAccept) eExp.push_back(d);
        else timeoutFail("e_send");
        @(posedge Clock); #1;
        eInValid = 1'b0;
    endtask

    // Reset discards everything the model holds, including a partially packed word.
    task automatic doReset();
        Reset = 1'b1;
        uExp.delete(); pExp.delete(); eExp.delete();
        pPartial = '0; pBeat = 0; uIdx = 0;
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((uExp.size() != 0 || pExp.size() != 0 || eExp.size() != 0) && n < 500) begin
            @(posedge Clock); n++;
        end
        #1;
        check("drain_unpack", 512'(uExp.size()), 512'd0);
        check("drain_pack",   512'(pExp.size()), 512'd0);
        check("drain_equal",  512'(eExp.size()), 512'd0);
    endtask

    // Monitors: compare the presented output against the queue head every valid cycle,
    // which also catches data changing while OutReady is stalled; pop on transfer.
    always @(negedge Clock) begin
        if (!Reset && uOutValid) begin
            if (uExp.size() == 0) timeoutFail("u_unexpected_output");
            else begin
                check("u_data", 512'(uOutData), 512'(uExp[0]));
                if (uOutReady) begin
                    check("u_accept_on_last_chunk", 512'(uInAccept), 512'(uIdx == 7));
                    uIdx = (uIdx + 1) % 8;
                    void'(uExp.pop_front());
                end
            end
        end
    end

    always @(negedge Clock) begin
        if (!Reset && pOutValid) begin
            if (pExp.size() == 0) timeoutFail("p_unexpected_output");
            else begin
                check("p_data", pOutData, pExp[0]);
                if (pOutReady) void'(pExp.pop_front());
            end
        end
    end

    always @(negedge Clock) begin
        if (!Reset) begin
            // A one-entry buffer may only refuse input while holding an undrained entry.
            check("e_single_entry", 512'(eInAccept), 512'(!eOutValid || eOutReady));
            if (eOutValid) begin
                if (eExp.size() == 0) timeoutFail("e_unexpected_output");
                else begin
                    check("e_data", 512'(eOutData), 512'(eExp[0]));
                    if (eOutReady) void'(eExp.pop_front());
                end
            end
        end
    end

    initial begin
        logic [511:0] word;
        Reset = 1'b1;
        uInValid = 1'b0; pInValid = 1'b0; eInValid = 1'b0;
        uInData = '0; pInData = '0; eInData = '0;
        repeat (3) @(posedge Clock);
        #1;
        Reset = 1'b0;

        // Reset state, first cycle after reset.
        @(negedge Clock);
        check("reset_u_accept", 512'(uInAccept), 512'd1);
        check("reset_p_accept", 512'(pInAccept), 512'd1);
        check("reset_e_accept", 512'(eInAccept), 512'd1);
        check("reset_u_valid",  512'(uOutValid), 512'd0);
        check("reset_p_valid",  512'(pOutValid), 512'd0);
        check("reset_e_valid",  512'(eOutValid), 512'd0);
        @(posedge Clock); #1;

        // 512->64 with chunk k = 0x1000+k.
        for (int k = 0; k < 8; k++) word[k*64 +: 64] = 64'h1000 + 64'(k);
        sendU(word);
        waitDrain();

        // 64->512 through the output register, with latency of the packed word.
        for (int k = 0; k < 8; k++) sendP(64'h20 + 64'(k));
        @(negedge Clock);
        check("p_latency_cycle1", 512'(pOutValid), 512'd0);
        @(posedge Clock); #1;
        @(negedge Clock);
        check("p_latency_cycle2", 512'(pOutValid), 512'd1);
        @(posedge Clock); #1;
        waitDrain();

        // Random backpressure on 512->64.
        uRand = 1;
        for (int w = 0; w < 4; w++) sendU(randWide());
        waitDrain();
        uRand = 0;
        repeat (2) @(posedge Clock);
        #1;

        // Two back-to-back 512-bit words must stream as 16 consecutive beats.
        fork
            begin
                sendU(randWide());
                sendU(randWide());
            end
            begin
                int n = 0;
                @(negedge Clock);
                while (!uOutValid && n < 20) begin @(negedge Clock); n++; end
                if (!uOutValid) timeoutFail("b2b_start");
                else for (int i = 0; i < 16; i++) begin
                    if (i > 0) @(negedge Clock);
                    check("b2b_transfer", 512'(uOutValid & uOutReady), 512'd1);
                end
            end
        join
        @(posedge Clock); #1;
        waitDrain();

        // Reset after 3 of 8 narrow beats; only the following word may appear.
        for (int k = 0; k < 3; k++) sendP(64'h300 + 64'(k));
        doReset();
        for (int k = 0; k < 8; k++) sendP(64'h500 + 64'(k));
        waitDrain();

        // Random pack traffic with random backpressure.
        pRand = 1;
        for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(0, 1)) @(posedge Clock);
            #0;
            sendP({$urandom, $urandom});
        end
        waitDrain();
        pRand = 0;

        // Equal widths: random valid gaps and random ready.
        eRand = 1;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge Clock); #1; end
            sendE({$urandom, $urandom});
        end
        waitDrain();
        eRand = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
